// File: rtl/ifetch_queue_if.sv
// Fetch-unit bundle: I-memory read port, redirect input and decode-side handshake.
interface ifetch_queue_if #(
  parameter int unsigned ISIZE = 16,
  parameter int unsigned DSIZE = 16,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             imem_req;
  logic [ISIZE-1:0] imem_addr;
  logic [DSIZE-1:0] imem_data;
  logic             redirect;
  logic [ISIZE-1:0] redirect_pc;
  logic             if_valid;
  logic             if_ready;
  logic [DSIZE-1:0] if_instr;
  logic [ISIZE-1:0] if_pc;
  logic [ISIZE-1:0] if_pcplus1;
  logic [CW-1:0]    count;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_pcplus1, count,
    input  imem_data, redirect, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_pcplus1, count,
    output imem_data, redirect, redirect_pc, if_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: sequential I-memory reads buffered in a FIFO toward decode,
// with epoch-tagged squash of buffered and in-flight words on redirect.
module ifetch_queue #(
  parameter int unsigned      ISIZE    = 16,
  parameter int unsigned      DSIZE    = 16,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [ISIZE-1:0] RESET_PC = '0
) (
  input logic            clk,
  input logic            rst,
  ifetch_queue_if.master bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [DSIZE-1:0] instr;
    logic [ISIZE-1:0] pc;
    logic [ISIZE-1:0] pcplus1;
  } entry_t;

  logic [ISIZE-1:0] fetch_pc_q, fetch_pc_d;
  logic             inflight_q, inflight_d;
  logic [ISIZE-1:0] tag_pc_q, tag_pc_d;
  logic             tag_epoch_q, tag_epoch_d;
  logic             epoch_q, epoch_d;
  entry_t           fifo_q [DEPTH];
  entry_t           fifo_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  logic             issue_c, push_c, pop_c;
  logic [CW:0]      occ_c;

  // Issue credit counts held plus in-flight words; a pop this cycle is not credited.
  always_comb begin
    occ_c   = {1'b0, count_q} + (CW+1)'(inflight_q);
    issue_c = rst && !bus.redirect && (occ_c < (CW+1)'(DEPTH));
    push_c  = inflight_q && (tag_epoch_q == epoch_q);
    pop_c   = (count_q != '0) && bus.if_ready;
  end

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    inflight_d  = issue_c;
    tag_pc_d    = tag_pc_q;
    tag_epoch_d = tag_epoch_q;
    epoch_d     = epoch_q;
    fifo_d      = fifo_q;
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;

    if (issue_c) begin
      tag_pc_d    = fetch_pc_q;
      tag_epoch_d = epoch_q;
    end

    // Redirect dominates: queue empties and any returning word becomes stale.
    if (bus.redirect) begin
      fetch_pc_d = bus.redirect_pc;
      epoch_d    = ~epoch_q;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
    end else begin
      if (issue_c) begin
        fetch_pc_d = fetch_pc_q + ISIZE'(1);
      end
      if (push_c) begin
        fifo_d[tail_q] = '{instr: bus.imem_data, pc: tag_pc_q, pcplus1: tag_pc_q + ISIZE'(1)};
        tail_d         = tail_q + PW'(1);
      end
      if (pop_c) begin
        head_d = head_q + PW'(1);
      end
      count_d = count_q + CW'(push_c) - CW'(pop_c);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q  <= RESET_PC;
      inflight_q  <= 1'b0;
      tag_pc_q    <= '0;
      tag_epoch_q <= 1'b0;
      epoch_q     <= 1'b0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      inflight_q  <= inflight_d;
      tag_pc_q    <= tag_pc_d;
      tag_epoch_q <= tag_epoch_d;
      epoch_q     <= epoch_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      fifo_q      <= fifo_d;
    end
  end

  assign bus.imem_req   = issue_c;
  assign bus.imem_addr  = fetch_pc_q;
  assign bus.if_valid   = (count_q != '0);
  assign bus.if_instr   = fifo_q[head_q].instr;
  assign bus.if_pc      = fifo_q[head_q].pc;
  assign bus.if_pcplus1 = fifo_q[head_q].pcplus1;
  assign bus.count      = count_q;

  // Issue gating keeps occupancy below DEPTH, so a push never lands on a full queue.
  a_no_push_full : assert property (@(posedge clk) disable iff (!rst)
    !(push_c && !bus.redirect && (count_q == CW'(DEPTH))));
endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: directed fetch/redirect/reset scenarios, decode side
// checked by a negedge monitor popping expected words.
module tb_ifetch_queue;
  localparam int unsigned ISIZE = 16;
  localparam int unsigned DSIZE = 16;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] pcp1;
  } exp_t;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic want_ready = 1'b0;
  exp_t exp_q[$];
  exp_t mon_e;

  ifetch_queue_if #(.ISIZE(ISIZE), .DSIZE(DSIZE), .DEPTH(DEPTH)) bus ();

  ifetch_queue #(.ISIZE(ISIZE), .DSIZE(DSIZE), .DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous I-memory model: mem[a] = a ^ A000, data one cycle after the strobe.
  always @(posedge clk) begin
    if (bus.imem_req) bus.imem_data <= bus.imem_addr ^ 16'hA000;
    else              bus.imem_data <= 16'hDEAD;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_exp(input logic [15:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = pc ^ 16'hA000;
    e.pcp1  = pc + 16'd1;
    exp_q.push_back(e);
  endfunction

  // Decode side only accepts while the scoreboard holds an expectation.
  task automatic tick();
    bus.if_ready = want_ready && (exp_q.size() > 0);
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_count(input string name, input logic [31:0] n, input int budget);
    int k = 0;
    while (32'(bus.count) != n && k < budget) begin
      tick();
      k++;
    end
    check(name, 32'(bus.count), n);
  endtask

  task automatic hold_reset();
    rst        = 1'b0;
    want_ready = 1'b0;
    bus.redirect = 1'b0;
    tick();
    tick();
  endtask

  // Monitor: every accepted head word is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst && bus.if_valid && bus.if_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_accept: got pc %h expected no word", bus.if_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("if_pc", 32'(bus.if_pc), 32'(mon_e.pc));
        check("if_instr", 32'(bus.if_instr), 32'(mon_e.instr));
        check("if_pcplus1", 32'(bus.if_pcplus1), 32'(mon_e.pcp1));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int reqs;
    rst             = 1'b1;
    bus.if_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    #1;
    hold_reset();

    // Reset values
    check("rst_if_valid", 32'(bus.if_valid), 32'd0);
    check("rst_imem_req", 32'(bus.imem_req), 32'd0);
    check("rst_imem_addr", 32'(bus.imem_addr), 32'h0000);
    check("rst_if_instr", 32'(bus.if_instr), 32'h0000);
    check("rst_if_pc", 32'(bus.if_pc), 32'h0000);
    check("rst_if_pcplus1", 32'(bus.if_pcplus1), 32'h0000);
    check("rst_count", 32'(bus.count), 32'd0);

    // 1: streaming from reset, one word per cycle, two-cycle latency
    for (int i = 0; i < 8; i++) push_exp(16'(i));
    want_ready = 1'b1;
    rst = 1'b1;
    settle();
    check("t1_first_req", 32'(bus.imem_req), 32'd1);
    check("t1_first_addr", 32'(bus.imem_addr), 32'h0000);
    tick();
    check("t1_no_bypass", 32'(bus.if_valid), 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("t1_no_gap", 32'(bus.if_valid), 32'd1);
      tick();
    end
    check("t1_drained", 32'(exp_q.size()), 32'd0);

    // 2: decode stalled from reset fills the queue, then drains in order
    hold_reset();
    rst = 1'b1;
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      settle();
      reqs += int'(bus.imem_req);
      tick();
    end
    check("t2_req_pulses", 32'(reqs), 32'd4);
    check("t2_count_full", 32'(bus.count), 32'd4);
    check("t2_head_held", 32'(bus.if_pc), 32'h0000);
    check("t2_fetch_stopped", 32'(bus.imem_addr), 32'h0004);
    for (int i = 0; i < 6; i++) push_exp(16'(i));
    want_ready = 1'b1;
    settle();
    check("t2_pop_not_credited", 32'(bus.imem_req), 32'd0);
    tick();
    check("t2_resume_req", 32'(bus.imem_req), 32'd1);
    check("t2_resume_addr", 32'(bus.imem_addr), 32'h0004);
    wait_empty("t2_drain_timeout", 20);

    // 3: redirect squashes 0003/0004 buffered and 0005 in flight
    hold_reset();
    for (int i = 0; i < 3; i++) push_exp(16'(i));
    want_ready = 1'b1;
    rst = 1'b1;
    wait_count("t3_setup_count", 32'd2, 20);
    check("t3_setup_head", 32'(bus.if_pc), 32'h0003);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    settle();
    check("t3_no_issue_on_redirect", 32'(bus.imem_req), 32'd0);
    tick();
    bus.redirect = 1'b0;
    push_exp(16'h0040);
    push_exp(16'h0041);
    settle();
    check("t3_flush_count", 32'(bus.count), 32'd0);
    check("t3_new_req", 32'(bus.imem_req), 32'd1);
    check("t3_new_addr", 32'(bus.imem_addr), 32'h0040);
    tick();
    check("t3_squash_valid", 32'(bus.if_valid), 32'd0);
    tick();
    check("t3_valid_3cyc", 32'(bus.if_valid), 32'd1);
    check("t3_pc_3cyc", 32'(bus.if_pc), 32'h0040);
    wait_empty("t3_drain_timeout", 20);

    // 4: redirect near the top of the address space wraps
    want_ready      = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    tick();
    bus.redirect = 1'b0;
    push_exp(16'hFFFE);
    push_exp(16'hFFFF);
    push_exp(16'h0000);
    want_ready = 1'b1;
    tick();
    tick();
    check("t4_pc", 32'(bus.if_pc), 32'hFFFE);
    check("t4_pcplus1", 32'(bus.if_pcplus1), 32'hFFFF);
    wait_empty("t4_drain_timeout", 20);

    // 5: asynchronous reset mid-cycle with three words buffered
    want_ready = 1'b0;
    hold_reset();
    rst = 1'b1;
    wait_count("t5_setup_count", 32'd3, 20);
    #1;
    rst = 1'b0;
    #1;
    check("t5_async_valid", 32'(bus.if_valid), 32'd0);
    check("t5_async_req", 32'(bus.imem_req), 32'd0);
    check("t5_async_count", 32'(bus.count), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    push_exp(16'h0000);
    push_exp(16'h0001);
    want_ready = 1'b1;
    settle();
    check("t5_restart_req", 32'(bus.imem_req), 32'd1);
    check("t5_restart_addr", 32'(bus.imem_addr), 32'h0000);
    wait_empty("t5_drain_timeout", 20);

    // 6: push+pop on one edge, then redirect on the same cycle as a pop
    hold_reset();
    rst = 1'b1;
    wait_count("t6_setup_count", 32'd2, 20);
    push_exp(16'h0000);
    want_ready = 1'b1;
    tick();
    check("t6_push_pop_count", 32'(bus.count), 32'd2);
    check("t6_push_pop_head", 32'(bus.if_pc), 32'h0001);
    push_exp(16'h0001);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    tick();
    bus.redirect = 1'b0;
    check("t6_pop_consumed", 32'(exp_q.size()), 32'd0);
    check("t6_redirect_count", 32'(bus.count), 32'd0);
    push_exp(16'h0100);
    push_exp(16'h0101);
    wait_empty("t6_drain_timeout", 20);
    want_ready = 1'b0;
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
